tie_state_bridge: RTL and testbench

- Parametrised TIE export-state to import-wire bridge for XTSC Verilog cosim.
- Carries a processor TIE export state (TIE_EXPSTATE) back into a TIE import wire (TIE_IMPWIRE) through a configurable register pipeline.
- Adds a per-write combine mode (pass, add-accumulate, XOR-accumulate), a sticky valid flag, change detection and a saturating change counter.
- Sits between the Xtensa core's TIE ports and cosim testbench logic.

---
 rtl/tie_state_bridge_if.sv | 38 +++
 rtl/tie_state_bridge.sv | 122 ++++++++++++
 tb/tb_tie_state_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tie_state_bridge_if.sv
// ---------------------------------------------------------------------------
// tie_state_bridge_if
//   Bundles the TIE export-state write side and the TIE import-wire read
//   side of tie_state_bridge.
//
//   master : cosim/core side. Drives TIE_EXPSTATE/TIE_EXPSTATE_WE and
//            observes the import wire, valid flag and change tracking.
//   slave  : the bridge itself.
//
//   Signals
//     TIE_EXPSTATE      [WIDTH]  exported state value
//     TIE_EXPSTATE_WE   [1]      write strobe; TIE_EXPSTATE sampled only when high
//     TIE_IMPWIRE       [WIDTH]  registered import wire value
//     TIE_IMPWIRE_VALID [1]      sticky, set once the first write reaches the output
//     CHANGE            [1]      one-cycle pulse while TIE_IMPWIRE shows a new value
//     CHANGE_COUNT      [CNT_W]  saturating count of CHANGE pulses
// ---------------------------------------------------------------------------
interface tie_state_bridge_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] TIE_EXPSTATE;
  logic             TIE_EXPSTATE_WE;
  logic [WIDTH-1:0] TIE_IMPWIRE;
  logic             TIE_IMPWIRE_VALID;
  logic             CHANGE;
  logic [CNT_W-1:0] CHANGE_COUNT;

  modport master (
    output TIE_EXPSTATE, TIE_EXPSTATE_WE,
    input  TIE_IMPWIRE, TIE_IMPWIRE_VALID, CHANGE, CHANGE_COUNT
  );

  modport slave (
    input  TIE_EXPSTATE, TIE_EXPSTATE_WE,
    output TIE_IMPWIRE, TIE_IMPWIRE_VALID, CHANGE, CHANGE_COUNT
  );
endinterface

// File: rtl/tie_state_bridge.sv
// ---------------------------------------------------------------------------
// tie_state_bridge
//   Carries a TIE export state back into a TIE import wire through a
//   LATENCY-deep register pipeline. Stage 0 is an accumulator that combines
//   each write according to MODE (0 pass, 1 add mod 2^WIDTH, 2 XOR); the
//   remaining stages are a plain delay line. The last stage drives the
//   import wire. A registered CHANGE pulse and a saturating CHANGE_COUNT
//   track every cycle in which the import wire takes a new, different value.
//
//   Ports
//     CLK    : clock, rising edge
//     RESET  : synchronous active-high reset; clears every stage and flag
//     bus    : tie_state_bridge_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module tie_state_bridge #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int MODE    = 0,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  tie_state_bridge_if.slave  bus
);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("tie_state_bridge: MODE must be 0, 1 or 2");
  end
  if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
    $error("tie_state_bridge: WIDTH must be in 1..256");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("tie_state_bridge: LATENCY must be in 1..8");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("tie_state_bridge: CNT_W must be in 1..32");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] din);
    case (MODE)
      1:       combine = acc + din;
      2:       combine = acc ^ din;
      default: combine = din;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    sat_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  endfunction

  // dat_p[0]/vld_p[0] are the accumulator and its valid flag; the last
  // entry is the output stage. With LATENCY=1 they are the same register.
  logic [WIDTH-1:0]   dat_p [LATENCY];
  logic [LATENCY-1:0] vld_p;
  logic [WIDTH-1:0]   acc_nxt;
  logic               vld_nxt;
  logic [WIDTH-1:0]   last_in_d;
  logic               last_in_v;
  logic               change_nxt;
  logic               change_q;
  logic [CNT_W-1:0]   count_q;

  // Stage 0 next state: TIE_EXPSTATE only enters through the WE mux, so an
  // undriven input while WE=0 never reaches the accumulator.
  always_comb begin
    acc_nxt = dat_p[0];
    vld_nxt = vld_p[0];
    if (bus.TIE_EXPSTATE_WE) begin
      acc_nxt = combine(dat_p[0], bus.TIE_EXPSTATE);
      vld_nxt = 1'b1;
    end
  end

  // What the output stage is about to load on this edge.
  if (LATENCY == 1) begin : g_lat1
    assign last_in_d = acc_nxt;
    assign last_in_v = vld_nxt;
  end else begin : g_latn
    assign last_in_d = dat_p[LATENCY-2];
    assign last_in_v = vld_p[LATENCY-2];
  end

  // Output stage starts at 0 after reset, so a first valid value of 0 sets
  // VALID without producing a pulse.
  assign change_nxt = last_in_v && (last_in_d != dat_p[LATENCY-1]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < LATENCY; i++) dat_p[i] <= '0;
      vld_p    <= '0;
      change_q <= 1'b0;
      count_q  <= '0;
    end else begin
      // ---- stage 0: accumulator ----
      dat_p[0] <= acc_nxt;
      vld_p[0] <= vld_nxt;
      // ---- stages 1..LATENCY-1: unconditional delay line ----
      for (int i = 1; i < LATENCY; i++) begin
        dat_p[i] <= dat_p[i-1];
        vld_p[i] <= vld_p[i-1];
      end
      // ---- change tracking, aligned with the output stage ----
      change_q <= change_nxt;
      if (change_nxt) count_q <= sat_inc(count_q);
    end
  end

  assign bus.TIE_IMPWIRE       = dat_p[LATENCY-1];
  assign bus.TIE_IMPWIRE_VALID = vld_p[LATENCY-1];
  assign bus.CHANGE            = change_q;
  assign bus.CHANGE_COUNT      = count_q;

`ifdef DISPLAY_IO
  always @(posedge CLK) begin
    if (change_q) $display("%0t tie_state_bridge TIE_IMPWIRE=0x%0h", $time, dat_p[LATENCY-1]);
  end
`endif

endmodule

// File: tb/tb_tie_state_bridge.sv
module tb_tie_state_bridge;
  localparam int N = 6;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [N-1:0] rst;

  // 0: MODE0 LAT2   1: MODE1 LAT2   2: MODE2 LAT2
  // 3: MODE0 LAT2 CNT_W=2   4: MODE0 LAT4   5: MODE0 LAT1
  tie_state_bridge_if #(.WIDTH(32), .CNT_W(16)) if0 ();
  tie_state_bridge_if #(.WIDTH(32), .CNT_W(16)) if1 ();
  tie_state_bridge_if #(.WIDTH(32), .CNT_W(16)) if2 ();
  tie_state_bridge_if #(.WIDTH(32), .CNT_W(2))  if3 ();
  tie_state_bridge_if #(.WIDTH(32), .CNT_W(16)) if4 ();
  tie_state_bridge_if #(.WIDTH(32), .CNT_W(16)) if5 ();

  tie_state_bridge #(.WIDTH(32), .LATENCY(2), .MODE(0), .CNT_W(16)) u0 (.CLK(CLK), .RESET(rst[0]), .bus(if0));
  tie_state_bridge #(.WIDTH(32), .LATENCY(2), .MODE(1), .CNT_W(16)) u1 (.CLK(CLK), .RESET(rst[1]), .bus(if1));
  tie_state_bridge #(.WIDTH(32), .LATENCY(2), .MODE(2), .CNT_W(16)) u2 (.CLK(CLK), .RESET(rst[2]), .bus(if2));
  tie_state_bridge #(.WIDTH(32), .LATENCY(2), .MODE(0), .CNT_W(2))  u3 (.CLK(CLK), .RESET(rst[3]), .bus(if3));
  tie_state_bridge #(.WIDTH(32), .LATENCY(4), .MODE(0), .CNT_W(16)) u4 (.CLK(CLK), .RESET(rst[4]), .bus(if4));
  tie_state_bridge #(.WIDTH(32), .LATENCY(1), .MODE(0), .CNT_W(16)) u5 (.CLK(CLK), .RESET(rst[5]), .bus(if5));

  typedef struct {
    int          sel;
    bit          r;
    bit          we;
    logic [31:0] din;
    logic [31:0] wire_e;
    bit          vld_e;
    bit          chg_e;
    int          cnt_e;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(int sel, bit r, bit we, logic [31:0] din,
                              logic [31:0] wire_e, bit vld_e, bit chg_e, int cnt_e);
    vec_t v;
    v.sel = sel; v.r = r; v.we = we; v.din = din;
    v.wire_e = wire_e; v.vld_e = vld_e; v.chg_e = chg_e; v.cnt_e = cnt_e;
    vecs.push_back(v);
  endfunction

  // Only the selected DUT sees a write; all others idle with X on data.
  task automatic drive(input int sel, input bit r, input bit we, input logic [31:0] din);
    rst = '0;
    rst[sel] = r;
    if0.TIE_EXPSTATE_WE = 1'b0; if0.TIE_EXPSTATE = 'x;
    if1.TIE_EXPSTATE_WE = 1'b0; if1.TIE_EXPSTATE = 'x;
    if2.TIE_EXPSTATE_WE = 1'b0; if2.TIE_EXPSTATE = 'x;
    if3.TIE_EXPSTATE_WE = 1'b0; if3.TIE_EXPSTATE = 'x;
    if4.TIE_EXPSTATE_WE = 1'b0; if4.TIE_EXPSTATE = 'x;
    if5.TIE_EXPSTATE_WE = 1'b0; if5.TIE_EXPSTATE = 'x;
    case (sel)
      0: begin if0.TIE_EXPSTATE_WE = we; if0.TIE_EXPSTATE = din; end
      1: begin if1.TIE_EXPSTATE_WE = we; if1.TIE_EXPSTATE = din; end
      2: begin if2.TIE_EXPSTATE_WE = we; if2.TIE_EXPSTATE = din; end
      3: begin if3.TIE_EXPSTATE_WE = we; if3.TIE_EXPSTATE = din; end
      4: begin if4.TIE_EXPSTATE_WE = we; if4.TIE_EXPSTATE = din; end
      default: begin if5.TIE_EXPSTATE_WE = we; if5.TIE_EXPSTATE = din; end
    endcase
  endtask

  task automatic sample(input int sel, output logic [31:0] w, output logic v,
                        output logic c, output int n);
    case (sel)
      0: begin w = if0.TIE_IMPWIRE; v = if0.TIE_IMPWIRE_VALID; c = if0.CHANGE; n = int'(if0.CHANGE_COUNT); end
      1: begin w = if1.TIE_IMPWIRE; v = if1.TIE_IMPWIRE_VALID; c = if1.CHANGE; n = int'(if1.CHANGE_COUNT); end
      2: begin w = if2.TIE_IMPWIRE; v = if2.TIE_IMPWIRE_VALID; c = if2.CHANGE; n = int'(if2.CHANGE_COUNT); end
      3: begin w = if3.TIE_IMPWIRE; v = if3.TIE_IMPWIRE_VALID; c = if3.CHANGE; n = int'(if3.CHANGE_COUNT); end
      4: begin w = if4.TIE_IMPWIRE; v = if4.TIE_IMPWIRE_VALID; c = if4.CHANGE; n = int'(if4.CHANGE_COUNT); end
      default: begin w = if5.TIE_IMPWIRE; v = if5.TIE_IMPWIRE_VALID; c = if5.CHANGE; n = int'(if5.CHANGE_COUNT); end
    endcase
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int sel, input logic [31:0] w_e,
                           input bit v_e, input bit c_e, input int n_e);
    logic [31:0] w;
    logic        v, c;
    int          n;
    sample(sel, w, v, c, n);
    check($sformatf("%s.wire", nm),  w, w_e);
    check($sformatf("%s.valid", nm), 32'(v), 32'(v_e));
    check($sformatf("%s.change", nm), 32'(c), 32'(c_e));
    check($sformatf("%s.count", nm), n, n_e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int cycles;

    // ---- global reset with a simultaneous write that must be discarded ----
    drive(0, 1'b0, 1'b0, 32'h0);
    rst = '1;
    if0.TIE_EXPSTATE_WE = 1'b1; if0.TIE_EXPSTATE = 32'hCAFE_F00D;
    if5.TIE_EXPSTATE_WE = 1'b1; if5.TIE_EXPSTATE = 32'hCAFE_F00D;
    tick();
    tick();
    for (int s = 0; s < N; s++) check_all($sformatf("reset[%0d]", s), s, 32'h0, 1'b0, 1'b0, 0);

    // ---- vector table: sel, rst, we, din, wire, valid, change, count ----
    // DUT0 MODE0 LAT2: reset dominates WE, then plan items 1 and 2
    add(0, 1, 1, 32'h0000_AAAA, 32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         32'h0,          0, 0, 0);
    add(0, 0, 1, 32'h1234_5678, 32'h0,          0, 0, 0);
    add(0, 0, 0, 32'h0,         32'h1234_5678,  1, 1, 1);
    add(0, 0, 0, 32'h0,         32'h1234_5678,  1, 0, 1);
    add(0, 0, 1, 32'h1234_5678, 32'h1234_5678,  1, 0, 1);
    add(0, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678,  1, 0, 1);
    add(0, 0, 0, 32'h0,         32'hDEAD_BEEF,  1, 1, 2);
    add(0, 0, 0, 32'h0,         32'hDEAD_BEEF,  1, 0, 2);
    // DUT1 MODE1: wrap-around add, then a zero write gives no pulse
    add(1, 0, 1, 32'hFFFF_FFFF, 32'h0,          0, 0, 0);
    add(1, 0, 1, 32'h0000_0002, 32'hFFFF_FFFF,  1, 1, 1);
    add(1, 0, 0, 32'h0,         32'h0000_0001,  1, 1, 2);
    add(1, 0, 1, 32'h0,         32'h0000_0001,  1, 0, 2);
    add(1, 0, 0, 32'h0,         32'h0000_0001,  1, 0, 2);
    // DUT2 MODE2: XOR accumulate
    add(2, 0, 1, 32'hA5A5_A5A5, 32'h0,          0, 0, 0);
    add(2, 0, 1, 32'hFFFF_0000, 32'hA5A5_A5A5,  1, 1, 1);
    add(2, 0, 1, 32'hA5A5_A5A5, 32'h5A5A_A5A5,  1, 1, 2);
    add(2, 0, 0, 32'h0,         32'hFFFF_0000,  1, 1, 3);
    add(2, 0, 0, 32'h0,         32'hFFFF_0000,  1, 0, 3);
    // DUT3 CNT_W=2: counter saturates at 3
    add(3, 0, 1, 32'd1,         32'd0,          0, 0, 0);
    add(3, 0, 1, 32'd2,         32'd1,          1, 1, 1);
    add(3, 0, 1, 32'd3,         32'd2,          1, 1, 2);
    add(3, 0, 1, 32'd4,         32'd3,          1, 1, 3);
    add(3, 0, 1, 32'd5,         32'd4,          1, 1, 3);
    add(3, 0, 0, 32'd0,         32'd5,          1, 1, 3);
    add(3, 0, 0, 32'd0,         32'd5,          1, 0, 3);
    // DUT5 LAT1: first write of 0 sets VALID without a pulse
    add(5, 0, 1, 32'h0,         32'h0,          1, 0, 0);
    add(5, 0, 1, 32'h7,         32'h7,          1, 1, 1);
    add(5, 0, 0, 32'h0,         32'h7,          1, 0, 1);
    add(5, 0, 1, 32'h7,         32'h7,          1, 0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].r, vecs[i].we, vecs[i].din);
      tick();
      check_all($sformatf("vec%0d_dut%0d", i, vecs[i].sel), vecs[i].sel,
                vecs[i].wire_e, vecs[i].vld_e, vecs[i].chg_e, vecs[i].cnt_e);
    end

    // ---- LAT4: reset mid-flight flushes 0x55 and discards 0x77 ----
    drive(4, 1'b0, 1'b1, 32'h55);
    tick();
    drive(4, 1'b0, 1'b0, 32'h0);
    tick();
    drive(4, 1'b1, 1'b1, 32'h77);
    tick();
    check_all("lat4_reset", 4, 32'h0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(4, 1'b0, 1'b0, 32'h0);
      tick();
      check_all($sformatf("lat4_flush%0d", k), 4, 32'h0, 1'b0, 1'b0, 0);
    end

    // ---- LAT4: next write appears exactly 3 edges after its write edge ----
    drive(4, 1'b0, 1'b1, 32'h99);
    tick();
    cycles = 1;
    while (if4.CHANGE !== 1'b1 && cycles < 12) begin
      check($sformatf("lat4_wait%0d.wire", cycles), if4.TIE_IMPWIRE, 32'h0);
      drive(4, 1'b0, 1'b0, 32'h0);
      tick();
      cycles++;
    end
    check("lat4_latency", cycles, 4);
    check_all("lat4_99", 4, 32'h99, 1'b1, 1'b1, 1);
    drive(4, 1'b0, 1'b0, 32'h0);
    tick();
    check_all("lat4_99_hold", 4, 32'h99, 1'b1, 1'b0, 1);

    // ---- reset after activity clears VALID and count on DUT0 ----
    drive(0, 1'b1, 1'b0, 32'h0);
    tick();
    check_all("dut0_rereset", 0, 32'h0, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
